// File: rtl/seq_pkg.sv
// seq_pkg -- shared types and constants for the program sequencer.
//   seqState_t  : sequencer FSM state encoding
//   haltOpcode  : halt instruction value (all ones) for a given instruction width
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } seqState_t;

   // Returned 32 bits wide; callers size-cast to their instruction width.
   function automatic logic [31:0] haltOpcode(input int instrW);
      if (instrW >= 32) return '1;
      return (32'd1 << instrW) - 32'd1;
   endfunction

endpackage

// File: rtl/seq_next_pc.sv
// seq_next_pc -- combinational next-PC selection for a retiring instruction.
//   ProgCtr  in  PC_W  current program counter
//   Jump     in  1     absolute branch, wins over BranchEn
//   BranchEn in  1     relative branch, taken when Zero=1
//   Zero     in  1     ALU zero flag
//   Target   in  PC_W  absolute target or two's-complement offset
//   NextPc   out PC_W  selected next program counter
// Halt handling is not done here: a halt freezes the PC in the FSM.
module seq_next_pc #(
   parameter int PC_W = 10
) (
   input  logic [PC_W-1:0] ProgCtr,
   input  logic            Jump,
   input  logic            BranchEn,
   input  logic            Zero,
   input  logic [PC_W-1:0] Target,
   output logic [PC_W-1:0] NextPc
);

   // Additions wrap modulo 2^PC_W; a negative offset is just a large Target.
   always_comb begin
      NextPc = ProgCtr + PC_W'(1);
      if (Jump)
         NextPc = Target;
      else if (BranchEn && Zero)
         NextPc = ProgCtr + Target;
   end

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer -- program sequencer: PC control, cycle/instruction counters,
// start/abort/done handshake and optional watchdog.
//   Clk         in  1        clock, posedge
//   Reset       in  1        async reset, active-low
//   Start       in  1        level request: arm/restart program
//   Stall       in  1        hold PC this cycle
//   Instruction in  INSTR_W  current instruction (all ones = halt)
//   Jump        in  1        absolute branch enable
//   BranchEn    in  1        relative branch enable, taken when Zero=1
//   Zero        in  1        ALU zero flag
//   Target      in  PC_W     absolute target or relative offset
//   ProgCtr     out PC_W     program counter
//   Ack         out 1        program done
//   Busy        out 1        running
//   CycleCt     out CNT_W    cycles spent running (saturating)
//   InstrCt     out CNT_W    instructions retired (saturating)
//   Timeout     out 1        watchdog fired
// Build option: define SEQ_WATCHDOG_EN to compile in the watchdog, which ends
// a run once CycleCt reaches WDOG_LIMIT. Undefined: Timeout is tied low.
//
// state | meaning
// IDLE  | after reset, waiting for Start
// ARM   | Start seen: PC and counters held at their start values
// RUN   | executing, one instruction retired per unstalled cycle
// DONE  | halted or timed out, results held until next Start
module prog_sequencer
   import seq_pkg::*;
#(
   parameter int              PC_W       = 10,
   parameter int              INSTR_W    = 9,
   parameter int              CNT_W      = 16,
   parameter logic [PC_W-1:0] START_ADDR = '0,
   parameter int              WDOG_LIMIT = 1000
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic               Stall,
   input  logic [INSTR_W-1:0] Instruction,
   input  logic               Jump,
   input  logic               BranchEn,
   input  logic               Zero,
   input  logic [PC_W-1:0]    Target,
   output logic [PC_W-1:0]    ProgCtr,
   output logic               Ack,
   output logic               Busy,
   output logic [CNT_W-1:0]   CycleCt,
   output logic [CNT_W-1:0]   InstrCt,
   output logic               Timeout
);

   localparam logic [INSTR_W-1:0] HALT_OP = INSTR_W'(haltOpcode(INSTR_W));
   localparam logic [CNT_W-1:0]   CNT_MAX = '1;

   // A limit the cycle counter can never reach would silently disable the watchdog.
   if (WDOG_LIMIT < 1 || WDOG_LIMIT >= (1 << CNT_W)) begin : gBadWdogLimit
      $error("prog_sequencer: WDOG_LIMIT must be in 1 .. 2^CNT_W-1");
   end

   seqState_t        state;
   logic             isHalt;
   logic [PC_W-1:0]  nextPc;
   logic [CNT_W-1:0] cycleInc;
   logic [CNT_W-1:0] instrInc;

   assign isHalt   = (Instruction == HALT_OP);
   assign cycleInc = (CycleCt == CNT_MAX) ? CycleCt : CycleCt + CNT_W'(1);
   assign instrInc = (InstrCt == CNT_MAX) ? InstrCt : InstrCt + CNT_W'(1);

   seq_next_pc #(.PC_W(PC_W)) uNextPc (
      .ProgCtr  (ProgCtr),
      .Jump     (Jump),
      .BranchEn (BranchEn),
      .Zero     (Zero),
      .Target   (Target),
      .NextPc   (nextPc)
   );

`ifdef SEQ_WATCHDOG_EN
   logic timeoutQ;
   logic wdogHit;

   assign wdogHit = (CycleCt >= CNT_W'(WDOG_LIMIT));
   assign Timeout = timeoutQ;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         timeoutQ <= 1'b0;
      else if (Start)
         timeoutQ <= 1'b0;
      else if (state == RUN && wdogHit)
         timeoutQ <= 1'b1;
   end
`else
   logic wdogHit;

   assign wdogHit = 1'b0;
   assign Timeout = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state   <= IDLE;
         ProgCtr <= START_ADDR;
         CycleCt <= '0;
         InstrCt <= '0;
         Ack     <= 1'b0;
         Busy    <= 1'b0;
      end else if (Start) begin
         // Start wins in every state, including an abort from RUN.
         state   <= ARM;
         ProgCtr <= START_ADDR;
         CycleCt <= '0;
         InstrCt <= '0;
         Ack     <= 1'b0;
         Busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ProgCtr <= START_ADDR;
               Ack     <= 1'b0;
               Busy    <= 1'b0;
            end
            ARM: begin
               state <= RUN;
               Busy  <= 1'b1;
            end
            RUN: begin
               if (wdogHit) begin
                  state <= DONE;
                  Busy  <= 1'b0;
                  Ack   <= 1'b1;
               end else if (Stall) begin
                  CycleCt <= cycleInc;
               end else if (isHalt) begin
                  // Halt is not retired and leaves the PC on the halt word.
                  state   <= DONE;
                  Busy    <= 1'b0;
                  Ack     <= 1'b1;
                  CycleCt <= cycleInc;
               end else begin
                  ProgCtr <= nextPc;
                  CycleCt <= cycleInc;
                  InstrCt <= instrInc;
               end
            end
            DONE: begin
               Ack  <= 1'b1;
               Busy <= 1'b0;
            end
            default: begin
               state <= IDLE;
               Ack   <= 1'b0;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer -- bench for prog_sequencer. Two instances share the
// inputs: uDut0 with default parameters, uDut1 with CNT_W=4 and WDOG_LIMIT=8.
// A cycle-level model of the program flow predicts every output each cycle;
// directed scenarios add hand-computed expectations.
module tb_prog_sequencer;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       Start = 1'b0;
   logic       Stall = 1'b0;
   logic [8:0] Instruction = 9'h005;
   logic       Jump = 1'b0;
   logic       BranchEn = 1'b0;
   logic       Zero = 1'b0;
   logic [9:0] Target = '0;

   logic [9:0]  pc0, pc1;
   logic        ack0, ack1, busy0, busy1, to0, to1;
   logic [15:0] cyc0, ins0;
   logic [3:0]  cyc1, ins1;

   int errors = 0;
   int checks = 0;
   bit cmpEn = 1'b0;

   always #5 Clk = ~Clk;

   prog_sequencer uDut0 (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
      .Instruction(Instruction), .Jump(Jump), .BranchEn(BranchEn),
      .Zero(Zero), .Target(Target), .ProgCtr(pc0), .Ack(ack0),
      .Busy(busy0), .CycleCt(cyc0), .InstrCt(ins0), .Timeout(to0)
   );

   prog_sequencer #(.CNT_W(4), .WDOG_LIMIT(8)) uDut1 (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
      .Instruction(Instruction), .Jump(Jump), .BranchEn(BranchEn),
      .Zero(Zero), .Target(Target), .ProgCtr(pc1), .Ack(ack1),
      .Busy(busy1), .CycleCt(cyc1), .InstrCt(ins1), .Timeout(to1)
   );

   // ---------------- reference model ----------------
   localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DONE = 3;
`ifdef SEQ_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif
   int cntMax[2] = '{65535, 15};
   int wdLim[2]  = '{1000, 8};
   int mMode[2]  = '{M_IDLE, M_IDLE};
   int mPc[2]    = '{0, 0};
   int mCyc[2]   = '{0, 0};
   int mIns[2]   = '{0, 0};
   int mTo[2]    = '{0, 0};

   always @(posedge Clk or negedge Reset) begin
      for (int k = 0; k < 2; k++) begin
         if (!Reset || Start) begin
            mMode[k] = Reset ? M_ARM : M_IDLE;
            mPc[k] = 0; mCyc[k] = 0; mIns[k] = 0; mTo[k] = 0;
         end else if (mMode[k] == M_ARM) begin
            mMode[k] = M_RUN;
         end else if (mMode[k] == M_RUN) begin
            if (WD && mCyc[k] >= wdLim[k]) begin
               mMode[k] = M_DONE;
               mTo[k] = 1;
            end else begin
               mCyc[k] = (mCyc[k] + 1 > cntMax[k]) ? cntMax[k] : mCyc[k] + 1;
               if (!Stall) begin
                  if (Instruction == 9'h1FF) mMode[k] = M_DONE;
                  else begin
                     mIns[k] = (mIns[k] + 1 > cntMax[k]) ? cntMax[k] : mIns[k] + 1;
                     if (Jump) mPc[k] = int'(Target);
                     else if (BranchEn && Zero) mPc[k] = (mPc[k] + int'(Target)) % 1024;
                     else mPc[k] = (mPc[k] + 1) % 1024;
                  end
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== 32'(exp)) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (cmpEn) begin
         check("m_pc0",   32'(pc0),   mPc[0]);
         check("m_ack0",  32'(ack0),  int'(mMode[0] == M_DONE));
         check("m_busy0", 32'(busy0), int'(mMode[0] == M_RUN));
         check("m_cyc0",  32'(cyc0),  mCyc[0]);
         check("m_ins0",  32'(ins0),  mIns[0]);
         check("m_to0",   32'(to0),   mTo[0]);
         check("m_pc1",   32'(pc1),   mPc[1]);
         check("m_ack1",  32'(ack1),  int'(mMode[1] == M_DONE));
         check("m_busy1", 32'(busy1), int'(mMode[1] == M_RUN));
         check("m_cyc1",  32'(cyc1),  mCyc[1]);
         check("m_ins1",  32'(ins1),  mIns[1]);
         check("m_to1",   32'(to1),   mTo[1]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input bit st, input bit sl, input logic [8:0] ins,
                      input bit j, input bit b, input bit z, input logic [9:0] tg);
      @(negedge Clk);
      #1;
      Start = st; Stall = sl; Instruction = ins;
      Jump = j; BranchEn = b; Zero = z; Target = tg;
      @(posedge Clk);
      #1;
   endtask

   task automatic plain();
      cyc(1'b0, 1'b0, 9'h005, 1'b0, 1'b0, 1'b0, 10'd0);
   endtask

   task automatic startRun();
      cyc(1'b1, 1'b0, 9'h005, 1'b0, 1'b0, 1'b0, 10'd0);
      plain();
   endtask

   initial begin
      repeat (2) @(negedge Clk);
      #1 Reset = 1'b1;
      cmpEn = 1'b1;

      // Stays idle after reset without Start.
      repeat (3) plain();
      check("idle_busy", 32'(busy0), 0);
      check("idle_pc",   32'(pc0),   0);
      check("idle_ack",  32'(ack0),  0);

      // Five plain instructions then halt.
      startRun();
      check("run_busy", 32'(busy0), 1);
      check("run_pc0",  32'(pc0),   0);
      repeat (5) plain();
      cyc(1'b0, 1'b0, 9'h1FF, 1'b0, 1'b0, 1'b0, 10'd0);
      check("halt_ack", 32'(ack0), 1);
      check("halt_pc",  32'(pc0),  5);
      check("halt_ins", 32'(ins0), 5);
      check("halt_cyc", 32'(cyc0), 6);
      check("halt_busy", 32'(busy0), 0);
      cyc(1'b0, 1'b1, 9'h005, 1'b1, 1'b1, 1'b1, 10'd77);
      check("done_hold_pc",  32'(pc0),  5);
      check("done_hold_ack", 32'(ack0), 1);

      // Stall, branches, jump priority, PC wrap, halt priority.
      startRun();
      repeat (4) plain();
      repeat (3) cyc(1'b0, 1'b1, 9'h005, 1'b0, 1'b0, 1'b0, 10'd0);
      check("stall_pc",  32'(pc0),  4);
      check("stall_cyc", 32'(cyc0), 7);
      check("stall_ins", 32'(ins0), 4);
      repeat (6) plain();
      check("pc_at10", 32'(pc0), 10);
      cyc(1'b0, 1'b0, 9'h005, 1'b0, 1'b1, 1'b1, 10'h3FE);
      check("br_back", 32'(pc0), 8);
      cyc(1'b0, 1'b0, 9'h005, 1'b1, 1'b0, 1'b0, 10'd10);
      cyc(1'b0, 1'b0, 9'h005, 1'b0, 1'b1, 1'b0, 10'h3FE);
      check("br_not_taken", 32'(pc0), 11);
      cyc(1'b0, 1'b0, 9'h005, 1'b1, 1'b0, 1'b0, 10'd10);
      cyc(1'b0, 1'b0, 9'h005, 1'b1, 1'b1, 1'b1, 10'd20);
      check("jump_prio", 32'(pc0), 20);
      cyc(1'b0, 1'b0, 9'h005, 1'b1, 1'b0, 1'b0, 10'h3FF);
      plain();
      check("pc_wrap", 32'(pc0), 0);
      cyc(1'b0, 1'b0, 9'h1FF, 1'b1, 1'b1, 1'b1, 10'd20);
      check("halt_prio_pc",  32'(pc0),  0);
      check("halt_prio_ack", 32'(ack0), 1);

      // Abort from RUN.
      startRun();
      repeat (3) plain();
      cyc(1'b1, 1'b0, 9'h005, 1'b0, 1'b0, 1'b0, 10'd0);
      check("abort_ack",  32'(ack0),  0);
      check("abort_busy", 32'(busy0), 0);
      check("abort_pc",   32'(pc0),   0);

      // Asynchronous reset mid-run at PC 7.
      plain();
      repeat (7) plain();
      check("pre_rst_pc", 32'(pc0), 7);
      #2 Reset = 1'b0;
      #1;
      check("rst_pc",   32'(pc0),   0);
      check("rst_busy", 32'(busy0), 0);
      check("rst_cyc",  32'(cyc0),  0);
      check("rst_ins",  32'(ins0),  0);
      check("rst_ack",  32'(ack0),  0);
      @(negedge Clk);
      #1 Reset = 1'b1;
      repeat (2) plain();
      check("post_rst_busy", 32'(busy0), 0);

`ifdef SEQ_WATCHDOG_EN
      // Tight loop on the small instance until the watchdog fires.
      begin
         int n = 0;
         startRun();
         while (!ack1 && n < 30) begin
            cyc(1'b0, 1'b0, 9'h005, 1'b1, 1'b0, 1'b0, 10'd0);
            n++;
         end
         check("wdog_ack", 32'(ack1), 1);
         check("wdog_to",  32'(to1),  1);
         check("wdog_cyc", 32'(cyc1), 8);
         cyc(1'b1, 1'b0, 9'h005, 1'b0, 1'b0, 1'b0, 10'd0);
         check("wdog_clear", 32'(to1), 0);
      end
`else
      // Saturation on the 4-bit counter instance.
      startRun();
      repeat (20) cyc(1'b0, 1'b1, 9'h005, 1'b0, 1'b0, 1'b0, 10'd0);
      check("sat_cyc1", 32'(cyc1), 15);
      check("sat_ins1", 32'(ins1), 0);
      check("sat_cyc0", 32'(cyc0), 20);
      check("no_wdog_to", 32'(to1), 0);
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            @(negedge Clk);
            #2 Reset = 1'b0;
            @(negedge Clk);
            #1 Reset = 1'b1;
         end
         cyc(($urandom_range(0, 39) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 24) == 0) ? 9'h1FF : 9'($urandom_range(0, 510)),
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)),
             10'($urandom_range(0, 1023)));
      end

      @(negedge Clk);
      #1 cmpEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
